r5p_soc_dma_copy: RTL

Word-copy engine acting as a manager on `r5p_bus_if`, the initiating end of the same bus our subordinate peripherals (GPIO, UART, memories) respond to. A start pulse with source, destination and word count makes it issue alternating read and write transfers until the count is exhausted, then pulse `done`. It sits beside the CPU on the SoC interconnect and offloads block moves such as memory-to-memory copies and table loads into peripherals.

---
 rtl/r5p_soc_dma_pkg.sv | 23 ++
 rtl/r5p_bus_if.sv | 35 +++
 rtl/r5p_soc_dma_copy.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/r5p_soc_dma_pkg.sv
// ---------------------------------------------------------------------------
// r5p_soc_dma_pkg
// Shared types and constants for the r5p_soc_dma_copy word-copy engine.
//   dma_state_e : engine FSM states (IDLE, RD, DAT, WR, DONE)
//   DMA_AW/DW/LW: default address, data and word-count widths
//   DMA_STRIDE  : byte distance between consecutive words at DMA_DW
// ---------------------------------------------------------------------------
package r5p_soc_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  localparam int unsigned DMA_AW     = 32;
  localparam int unsigned DMA_DW     = 32;
  localparam int unsigned DMA_LW     = 16;
  localparam int unsigned DMA_STRIDE = DMA_DW / 8;

endpackage : r5p_soc_dma_pkg

// File: rtl/r5p_bus_if.sv
// ---------------------------------------------------------------------------
// r5p_bus_if
// Simple valid/ready SoC bus shared by managers (CPU, DMA) and subordinates
// (GPIO, UART, memories).
//   vld/rdy : transfer request and acceptance; a transfer happens on vld&rdy
//   wen     : 1 = write, 0 = read
//   adr     : byte address (AW bits)
//   ben     : byte enables (DW/8 bits)
//   wdt     : write data, valid with a write request
//   rdt     : read data, valid in the cycle after the read handshake
// ---------------------------------------------------------------------------
interface r5p_bus_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic            vld;
  logic            rdy;
  logic            wen;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] ben;
  logic [DW-1:0]   wdt;
  logic [DW-1:0]   rdt;

  modport man (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt
  );

  modport sub (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt
  );

endinterface : r5p_bus_if

// File: rtl/r5p_soc_dma_copy.sv
// ---------------------------------------------------------------------------
// r5p_soc_dma_copy
// Word-copy engine acting as a manager on r5p_bus_if. A start pulse latches
// source, destination and word count; the engine then issues alternating
// read and write transfers (RD -> DAT -> WR per word) until the count is
// exhausted, and pulses done for one cycle.
//
// Ports:
//   clk    : system clock (same as the bus)
//   rst    : synchronous, active-high reset
//   start  : one-cycle request, only honoured in IDLE
//   src    : source byte address (word aligned)
//   dst    : destination byte address (word aligned)
//   len    : number of words to move (0 = no transfer, just done)
//   fill   : fill-mode select (only active with R5P_SOC_DMA_FILL_EN)
//   pat    : fill pattern       (only active with R5P_SOC_DMA_FILL_EN)
//   busy   : high from the cycle after an accepted start through done
//   done   : one-cycle completion pulse
//   bus    : r5p_bus_if manager port
//
// Build option R5P_SOC_DMA_FILL_EN: when defined, fill=1 skips the read
// phase and writes pat to every destination word (one cycle per word with
// rdy high). When undefined, fill/pat are ignored and every job is a copy.
// ---------------------------------------------------------------------------
module r5p_soc_dma_copy
  import r5p_soc_dma_pkg::*;
#(
  parameter int unsigned AW = DMA_AW,
  parameter int unsigned DW = DMA_DW,
  parameter int unsigned LW = DMA_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic          fill,
  input  logic [DW-1:0] pat,
  output logic          busy,
  output logic          done,
  r5p_bus_if.man        bus
);

  // Package stride is defined for DMA_DW; scale it to this instance's width.
  localparam logic [AW-1:0] STRIDE  = AW'(DMA_STRIDE * DW / DMA_DW);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);
  localparam int unsigned   BW      = DW / 8;

  dma_state_e      state_q, state_d;
  logic [AW-1:0]   src_q,   src_d;
  logic [AW-1:0]   dst_q,   dst_d;
  logic [LW-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]   data_q,  data_d;
  logic            fill_q,  fill_d;
  logic [DW-1:0]   pat_q,   pat_d;

  logic            vld_q,   vld_d;
  logic            wen_q,   wen_d;
  logic [AW-1:0]   adr_q,   adr_d;
  logic [BW-1:0]   ben_q,   ben_d;
  logic [DW-1:0]   wdt_q,   wdt_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  logic            fill_in_s;
  logic [DW-1:0]   pat_in_s;

`ifdef R5P_SOC_DMA_FILL_EN
  assign fill_in_s = fill;
  assign pat_in_s  = pat;
`else
  // Fill inputs exist for port compatibility only; fold them away.
  logic unused_fill_s;
  assign fill_in_s     = 1'b0;
  assign pat_in_s      = {DW{1'b0}};
  assign unused_fill_s = ^{fill, pat};
`endif

  // Next-state, job registers, then registered bus outputs decoded from the
  // next state so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    vld_d   = 1'b0;
    wen_d   = wen_q;
    adr_d   = adr_q;
    ben_d   = ben_q;
    wdt_d   = wdt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          cnt_d  = len;
          fill_d = fill_in_s;
          pat_d  = pat_in_s;
          if (len == {LW{1'b0}}) begin
            state_d = ST_DONE;
          end else if (fill_in_s) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        // vld is held high in RD, so rdy alone completes the handshake.
        if (bus.rdy) begin
          state_d = ST_DAT;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DAT: begin
        // Subordinate presents read data one cycle after the handshake.
        data_d  = bus.rdt;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (bus.rdy) begin
          src_d = src_q + STRIDE;
          dst_d = dst_q + STRIDE;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else if (fill_q) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_RD: begin
        vld_d  = 1'b1;
        wen_d  = 1'b0;
        adr_d  = src_d;
        ben_d  = {BW{1'b1}};
        busy_d = 1'b1;
      end
      ST_WR: begin
        vld_d  = 1'b1;
        wen_d  = 1'b1;
        adr_d  = dst_d;
        ben_d  = {BW{1'b1}};
        busy_d = 1'b1;
        if (fill_d) begin
          wdt_d = pat_d;
        end else begin
          wdt_d = data_d;
        end
      end
      ST_DAT: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, job registers and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= {AW{1'b0}};
      dst_q   <= {AW{1'b0}};
      cnt_q   <= {LW{1'b0}};
      data_q  <= {DW{1'b0}};
      fill_q  <= 1'b0;
      pat_q   <= {DW{1'b0}};
      vld_q   <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= {AW{1'b0}};
      ben_q   <= {BW{1'b0}};
      wdt_q   <= {DW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      vld_q   <= vld_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      ben_q   <= ben_d;
      wdt_q   <= wdt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vld = vld_q;
  assign bus.wen = wen_q;
  assign bus.adr = adr_q;
  assign bus.ben = ben_q;
  assign bus.wdt = wdt_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule : r5p_soc_dma_copy
